run_detector: RTL and testbench

RUN_DETECTOR -- requirements
Module: run_detector

---
 rtl/run_detector.sv | 170 +++++++++++++++++
 tb/tb_run_detector.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/run_detector.sv
// ============================================================================
//  Module   : run_detector
//  Purpose  : Serial run-length detector. Tracks the polarity and length of
//             the current run of equal bits on w and flags a detection once
//             the run reaches RUN_LEN bits. Detection is gated per polarity
//             by mode.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock     in   1      rising-edge clock
//    reset     in   1      asynchronous, active-low reset
//    en        in   1      sample enable; w is consumed only when en=1
//    clr       in   1      synchronous clear, active-high, beats en
//    w         in   1      serial data bit
//    mode      in   2      bit0 enables runs of 1s, bit1 enables runs of 0s
//    state     out  2      registered FSM state (IDLE=00, RUN=01, HIT=10)
//    run_val   out  1      registered polarity of the current run
//    run_len   out  CNT_W  registered run length, saturating
//    z         out  1      combinational detection level
//    z_pulse   out  1      registered one-cycle detection strobe
//    event_cnt out  CNT_W  registered detection count, saturating
// ============================================================================
`default_nettype none

module run_detector #(
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             w,
  input  logic [1:0]       mode,
  output logic [1:0]       state,
  output logic             run_val,
  output logic [CNT_W-1:0] run_len,
  output logic             z,
  output logic             z_pulse,
  output logic [CNT_W-1:0] event_cnt
);

  // --------------------------------------------------------------------------
  // State encoding. 2'b11 is never entered; it is treated like IDLE so that
  // an upset register recovers on the next enabled sample.
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HIT    = 2'b10,
    UNUSED = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] c_len_max   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_len_hit   = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] c_len_pre   = CNT_W'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] c_len_one   = CNT_W'(1);

  // --------------------------------------------------------------------------
  // Registers and next-state values
  // --------------------------------------------------------------------------
  state_t           state_q,     state_d;
  logic             run_val_q,   run_val_d;
  logic [CNT_W-1:0] run_len_q,   run_len_d;
  logic             z_pulse_q,   z_pulse_d;
  logic [CNT_W-1:0] event_cnt_q, event_cnt_d;

  // --------------------------------------------------------------------------
  // Helper decodes for the enabled-sample path
  // --------------------------------------------------------------------------
  logic             w_no_run;      // no run in progress (IDLE or stray code)
  logic             w_new_run;     // this sample starts a fresh run
  logic [CNT_W-1:0] w_len_next;    // run length after this sample
  logic             w_mode_bit;    // mode bit gating the polarity of w
  logic             w_cross;       // run length crosses RUN_LEN-1 -> RUN_LEN
  logic             w_hit_pulse;   // qualified detection on this sample

  always_comb begin
    w_no_run   = (state_q == IDLE) || (state_q == UNUSED);
    w_new_run  = w_no_run || (w != run_val_q);

    // Saturate instead of wrapping so a very long run never falls back
    // below RUN_LEN and fakes a second detection.
    if (w_new_run) begin
      w_len_next = c_len_one;
    end else if (run_len_q == c_len_max) begin
      w_len_next = c_len_max;
    end else begin
      w_len_next = run_len_q + c_len_one;
    end

    // On a continuing run w equals run_val, so w selects the mode bit for
    // the run polarity seen at this edge.
    w_mode_bit  = w ? mode[0] : mode[1];

    // Only the exact crossing counts: a run that is already past RUN_LEN
    // when its polarity becomes enabled raises z but never pulses.
    w_cross     = !w_new_run && (run_len_q == c_len_pre);
    w_hit_pulse = w_cross && w_mode_bit;
  end

  // --------------------------------------------------------------------------
  // Next-state logic: clr beats en, en beats hold.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    run_val_d   = run_val_q;
    run_len_d   = run_len_q;
    event_cnt_d = event_cnt_q;
    z_pulse_d   = 1'b0;

    if (clr) begin
      state_d     = IDLE;
      run_val_d   = 1'b0;
      run_len_d   = '0;
      event_cnt_d = '0;
    end else if (en) begin
      run_val_d = w;
      run_len_d = w_len_next;

      // HIT is a pure function of the updated length, so saturation keeps
      // the FSM in HIT for as long as the run lasts.
      if (w_len_next >= c_len_hit) begin
        state_d = HIT;
      end else begin
        state_d = RUN;
      end

      if (w_hit_pulse) begin
        z_pulse_d = 1'b1;
        if (event_cnt_q != c_len_max) begin
          event_cnt_d = event_cnt_q + c_len_one;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      run_val_q   <= 1'b0;
      run_len_q   <= '0;
      z_pulse_q   <= 1'b0;
      event_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      run_val_q   <= run_val_d;
      run_len_q   <= run_len_d;
      z_pulse_q   <= z_pulse_d;
      event_cnt_q <= event_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. z is deliberately combinational on mode so that enabling or
  // disabling a polarity takes effect in the same cycle.
  // --------------------------------------------------------------------------
  assign state     = state_q;
  assign run_val   = run_val_q;
  assign run_len   = run_len_q;
  assign z_pulse   = z_pulse_q;
  assign event_cnt = event_cnt_q;
  assign z         = (state_q == HIT) && (run_val_q ? mode[0] : mode[1]);

endmodule

`default_nettype wire

// File: tb/tb_run_detector.sv
// ============================================================================
//  Module   : tb_run_detector
//  Purpose  : Self-checking bench for run_detector (RUN_LEN=4, CNT_W=8).
//             A behavioural model predicts each edge, predictions are queued
//             when stimulus is driven and compared after the edge.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_run_detector;

  localparam int RUN_LEN = 4;
  localparam int CNT_W   = 8;
  localparam int MAXV    = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             en    = 1'b0;
  logic             clr   = 1'b0;
  logic             w     = 1'b0;
  logic [1:0]       mode  = 2'b00;
  logic [1:0]       state;
  logic             run_val;
  logic [CNT_W-1:0] run_len;
  logic             z;
  logic             z_pulse;
  logic [CNT_W-1:0] event_cnt;

  run_detector #(.RUN_LEN(RUN_LEN), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .clr       (clr),
    .w         (w),
    .mode      (mode),
    .state     (state),
    .run_val   (run_val),
    .run_len   (run_len),
    .z         (z),
    .z_pulse   (z_pulse),
    .event_cnt (event_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    int st;
    int val;
    int len;
    int pulse;
    int cnt;
    int zz;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  int m_st  = 0;
  int m_val = 0;
  int m_len = 0;
  int m_cnt = 0;
  int m_pls = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_val = 0; m_len = 0; m_cnt = 0; m_pls = 0;
  endtask

  // Model of one rising edge given the inputs currently driven.
  task automatic model_edge();
    int  old_len;
    bit  fresh;
    bit  enabled;
    m_pls = 0;
    if (clr) begin
      m_st = 0; m_val = 0; m_len = 0; m_cnt = 0;
    end else if (en) begin
      old_len = m_len;
      fresh   = (m_st == 0) || (m_st == 3) || (int'(w) != m_val);
      enabled = (w == 1'b1) ? mode[0] : mode[1];
      if (fresh) begin
        m_len = 1;
      end else if (m_len < MAXV) begin
        m_len = m_len + 1;
      end
      m_val = int'(w);
      m_st  = (m_len >= RUN_LEN) ? 2 : 1;
      if (!fresh && old_len == RUN_LEN - 1 && m_len == RUN_LEN && enabled) begin
        m_pls = 1;
        if (m_cnt < MAXV) m_cnt = m_cnt + 1;
      end
    end
  endtask

  // Drive one cycle, queue the prediction, then compare after the edge.
  task automatic cyc(input logic i_en, input logic i_clr, input logic i_w, input logic [1:0] i_mode);
    exp_t e;
    exp_t g;
    en = i_en; clr = i_clr; w = i_w; mode = i_mode;
    model_edge();
    e.st    = m_st;
    e.val   = m_val;
    e.len   = m_len;
    e.pulse = m_pls;
    e.cnt   = m_cnt;
    e.zz    = (m_st == 2 && ((m_val != 0) ? mode[0] : mode[1])) ? 1 : 0;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    g = exp_q.pop_front();
    check("state",     32'(state),     32'(g.st));
    check("run_val",   32'(run_val),   32'(g.val));
    check("run_len",   32'(run_len),   32'(g.len));
    check("z_pulse",   32'(z_pulse),   32'(g.pulse));
    check("event_cnt", 32'(event_cnt), 32'(g.cnt));
    check("z",         32'(z),         32'(g.zz));
  endtask

  task automatic ones(input int n, input logic [1:0] md);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b1, md);
  endtask

  task automatic do_clr();
    cyc(1'b0, 1'b1, 1'b0, mode);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    // Reset state
    #2;
    check("rst_state", 32'(state), 0);
    check("rst_len",   32'(run_len), 0);
    check("rst_cnt",   32'(event_cnt), 0);
    check("rst_z",     32'(z), 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();

    // Five 1s, both polarities enabled
    ones(5, 2'b11);
    check("r031_cnt", 32'(event_cnt), 1);
    check("r031_len", 32'(run_len), 5);
    check("r031_z",   32'(z), 1);
    do_clr();

    // 0-run ignored by mode=01, 1-run detected
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 2'b01);
    check("r032_z0", 32'(z), 0);
    ones(4, 2'b01);
    check("r032_z1",  32'(z), 1);
    check("r032_cnt", 32'(event_cnt), 1);
    do_clr();

    // Broken run restarts
    ones(3, 2'b11);
    cyc(1'b1, 1'b0, 1'b0, 2'b11);
    check("r033_len1", 32'(run_len), 1);
    ones(4, 2'b11);
    check("r033_cnt", 32'(event_cnt), 1);
    do_clr();

    // en gap does not break the run
    ones(2, 2'b11);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 2'b11);
    check("r034_gap_pulse", 32'(z_pulse), 0);
    ones(2, 2'b11);
    check("r034_pulse", 32'(z_pulse), 1);
    do_clr();

    // Late-enabled run: z without pulse or count
    ones(6, 2'b10);
    check("r026_z_off", 32'(z), 0);
    mode = 2'b01;
    #1;
    check("r026_z_comb", 32'(z), 1);
    ones(2, 2'b01);
    check("r026_cnt", 32'(event_cnt), 0);
    do_clr();

    // Asynchronous reset mid-run
    ones(3, 2'b11);
    #2;
    reset = 1'b0;
    #1;
    check("r036_rst_state", 32'(state), 0);
    check("r036_rst_len",   32'(run_len), 0);
    check("r036_rst_val",   32'(run_val), 0);
    check("r036_rst_z",     32'(z), 0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    ones(3, 2'b11);
    check("r036_no_early", 32'(z_pulse), 0);
    ones(1, 2'b11);
    check("r036_pulse", 32'(z_pulse), 1);
    // clr beats en
    cyc(1'b1, 1'b1, 1'b1, 2'b11);
    check("r036_clr_len", 32'(run_len), 0);

    // Saturation of run_len and event_cnt
    ones(300, 2'b11);
    check("r035_len", 32'(run_len), 255);
    check("r035_state", 32'(state), 2);
    check("r035_cnt1", 32'(event_cnt), 1);
    for (int r = 0; r < 260; r++) begin
      for (int b = 0; b < 4; b++) cyc(1'b1, 1'b0, r[0] ? 1'b1 : 1'b0, 2'b11);
    end
    check("r035_cnt_sat", 32'(event_cnt), 255);
    do_clr();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 3) != 0) ? w : ~w,
          2'($urandom_range(0, 3)));
    end

    if (exp_q.size() != 0) check("queue_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
